alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue stage directly upstream of wrapper_alu. Accepts 16-bit instructions over a valid/ready
//  handshake and reads operands from an internal register file. Drives alu_en/alu_func/a/b to the
//  ALU, waits a fixed ALU latency, then writes the ALU result back and reports it.
//  Opcode 4'hF (LDI) bypasses the ALU.
// PARAMETERS
//  DATA_W       16  datapath width (a, b, alu_out, registers)
//  NREGS        16  register count; index width fixed at 4
//  ALU_LATENCY  1   cycles alu_out needs after alu_en/operands go valid; legal range >=1
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-low; all state cleared while low
//  instr_valid  in   1       upstream instruction valid
//  instr_ready  out  1       block can accept an instruction this cycle
//  instr        in   16      [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt; LDI: [7:0] imm8
//  alu_en       out  1       to ALU: operation active
//  alu_func     out  4       to ALU: function (= op for op 0..14)
//  a            out  DATA_W  to ALU: rf[rs]
//  b            out  DATA_W  to ALU: rf[rt]
//  alu_out      in   DATA_W  from ALU: result
//  wb_valid     out  1       one-cycle pulse: a write-back occurred
//  wb_rd        out  4       destination of that write-back
//  wb_data      out  DATA_W  value written
//  dbg_addr     in   4       debug register select
//  dbg_data     out  DATA_W  combinational rf[dbg_addr]
// BEHAVIOUR
//  Reset (reset=0): state IDLE; all registers 0; alu_en, alu_func, a, b, wb_valid, wb_rd and
//   wb_data are 0. instr_ready=1 once reset=1. Any in-flight op is dropped with no write-back.
//  States: IDLE, EXEC.
//  IDLE: instr_ready=1. On an edge with instr_valid=1:
//   - op!=4'hF: latch alu_func=op, a=rf[rs], b=rf[rt], rd; set alu_en=1; load cnt=ALU_LATENCY-1;
//     go to EXEC.
//   - op==4'hF (LDI): rf[rd] <= {zero-extend imm8}; wb_valid=1, wb_rd=rd, wb_data=imm8 next cycle;
//     stay IDLE. Back-to-back LDIs are accepted every cycle.
//  EXEC: instr_ready=0. alu_en, alu_func, a and b are held stable. cnt decrements each edge.
//   On the edge with cnt==0: rf[rd] <= alu_out; wb_data=alu_out, wb_rd=rd, wb_valid=1 for one
//   cycle; alu_en=0; go to IDLE.
//   alu_en is therefore high for exactly ALU_LATENCY cycles.
//   Accept-to-wb_valid = ALU_LATENCY+1 edges. Issue interval = ALU_LATENCY+1 cycles.
//  After EXEC, alu_func/a/b keep their last values until the next accept.
//  wb_valid is 0 in every cycle not named above.
//  Hazards: the write occurs on the edge before IDLE. A following instruction (accepted in the
//   wb_valid cycle) reads the updated value. No forwarding is needed.
//  R0 is hardwired to 0: writes are discarded, but wb_valid/wb_rd=0/wb_data still report the
//   value. Reads of R0 (rs, rt, dbg) return 0.
//  instr_valid while instr_ready=0 is ignored; upstream holds instr until accepted.
//  Arithmetic belongs to the ALU; this block performs no width changes except the LDI
//   zero-extend.
// STRUCTURE
//  Shared package minigpu_pkg: OP_LDI=4'hF, instr field bit positions, state enum {IDLE,EXEC}.
//  Sub-module alu_regfile: NREGS x DATA_W, R0 hardwired to 0, 2 combinational read ports
//   (rs, rt), 1 debug read port, 1 synchronous write port, async active-low clear.
// TESTING  (bench ALU model: out=a+b for func 0, a-b for func 1, valid ALU_LATENCY cycles
//           after alu_en rises)
//  1 Reset: hold reset=0 for 3 cycles, then release -> all outputs 0, instr_ready=1,
//    dbg_data=0 for every dbg_addr.
//  2 instr=16'hF10A (LDI R1,10) -> next cycle wb_valid=1, wb_rd=1, wb_data=10;
//    dbg_addr=1 gives dbg_data=10.
//  3 LDI R2,5, then 16'h0312 (ADD R3,R1,R2) -> alu_en high ALU_LATENCY cycles with
//    alu_func=0, a=10, b=5; then wb_valid, wb_rd=3, wb_data=15; instr_ready low during EXEC.
//  4 Back-to-back: present 16'h0433 the cycle wb_valid for R3 is high -> accepted; a=b=15;
//    write-back R4=30. Then 16'h1541 (SUB R5,R4,R1) -> wb_data=20.
//  5 16'hF055 (LDI R0,0x55) -> wb_valid=1, wb_rd=0, wb_data=0x55, dbg R0 reads 0.
//    Instr with rs=0 then gets a=0.
//  6 Assert reset mid-EXEC -> alu_en=0 immediately, no wb_valid, all registers read 0
//    after release.
//    Rerun scenarios 3-4 with ALU_LATENCY=3 -> alu_en high 3 cycles, accept-to-wb = 4 edges.

Source files
------------

// File: rtl/minigpu_pkg.sv
// Shared definitions for the minigpu issue path: opcodes, instruction field
// positions and the issue-stage state encoding.
package minigpu_pkg;

    localparam logic [3:0] OP_LDI = 4'hF;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the issue stage: R0 reads as zero, two operand read ports,
// one debug read port, one synchronous write port.
module alu_regfile
    import minigpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        rs_addr,
    input  logic [3:0]        rt_addr,
    input  logic [3:0]        dbg_addr,
    input  logic              we,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_r [NREGS];

    // Register storage: cleared on reset, writes to R0 are discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we && (wr_addr != 4'd0)) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    assign rs_data  = (rs_addr  == 4'd0) ? {DATA_W{1'b0}} : regs_r[rs_addr];
    assign rt_data  = (rt_addr  == 4'd0) ? {DATA_W{1'b0}} : regs_r[rt_addr];
    assign dbg_data = (dbg_addr == 4'd0) ? {DATA_W{1'b0}} : regs_r[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the ALU: accepts one instruction at a time, holds the
// ALU operands for a fixed latency, then writes the result back. LDI skips the ALU.
module alu_issue_ctrl
    import minigpu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NREGS       = 16,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic              alu_en,
    output logic [3:0]        alu_func,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] alu_out,
    output logic              wb_valid,
    output logic [3:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    state_e            state_r;
    state_e            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [3:0]        rd_r;
    logic              alu_en_r;
    logic [3:0]        alu_func_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic              wb_valid_r;
    logic [3:0]        wb_rd_r;
    logic [DATA_W-1:0] wb_data_r;

    logic [3:0]        op_s;
    logic [3:0]        rd_s;
    logic [3:0]        rs_s;
    logic [3:0]        rt_s;
    logic [DATA_W-1:0] imm_ext_s;
    logic [DATA_W-1:0] rs_data_s;
    logic [DATA_W-1:0] rt_data_s;
    logic              issue_s;
    logic              rf_we_s;
    logic [3:0]        rf_wa_s;
    logic [DATA_W-1:0] rf_wd_s;

    assign op_s      = instr[OP_MSB:OP_LSB];
    assign rd_s      = instr[RD_MSB:RD_LSB];
    assign rs_s      = instr[RS_MSB:RS_LSB];
    assign rt_s      = instr[RT_MSB:RT_LSB];
    assign imm_ext_s = {{(DATA_W-8){1'b0}}, instr[IMM_MSB:IMM_LSB]};

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs_addr  (rs_s),
        .rt_addr  (rt_s),
        .dbg_addr (dbg_addr),
        .we       (rf_we_s),
        .wr_addr  (rf_wa_s),
        .wr_data  (rf_wd_s),
        .rs_data  (rs_data_s),
        .rt_data  (rt_data_s),
        .dbg_data (dbg_data)
    );

    // Next-state decode plus the single register-file write port (LDI or ALU result).
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        rf_we_s = 1'b0;
        rf_wa_s = rd_r;
        rf_wd_s = alu_out;
        case (state_r)
            IDLE: begin
                if (instr_valid) begin
                    if (op_s == OP_LDI) begin
                        rf_we_s = 1'b1;
                        rf_wa_s = rd_s;
                        rf_wd_s = imm_ext_s;
                        state_s = IDLE;
                    end else begin
                        issue_s = 1'b1;
                        state_s = EXEC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    rf_we_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = EXEC;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latency counter and all registered outputs towards ALU and write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            rd_r       <= 4'd0;
            alu_en_r   <= 1'b0;
            alu_func_r <= 4'd0;
            a_r        <= {DATA_W{1'b0}};
            b_r        <= {DATA_W{1'b0}};
            wb_valid_r <= 1'b0;
            wb_rd_r    <= 4'd0;
            wb_data_r  <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_s;
            wb_valid_r <= rf_we_s;
            if (rf_we_s) begin
                wb_rd_r   <= rf_wa_s;
                wb_data_r <= rf_wd_s;
            end
            if (issue_s) begin
                alu_en_r   <= 1'b1;
                alu_func_r <= op_s;
                a_r        <= rs_data_s;
                b_r        <= rt_data_s;
                rd_r       <= rd_s;
                cnt_r      <= CNT_W'(ALU_LATENCY - 1);
            end else if (state_r == EXEC) begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    alu_en_r <= 1'b0;
                end else begin
                    cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign instr_ready = (state_r == IDLE);
    assign alu_en      = alu_en_r;
    assign alu_func    = alu_func_r;
    assign a           = a_r;
    assign b           = b_r;
    assign wb_valid    = wb_valid_r;
    assign wb_rd       = wb_rd_r;
    assign wb_data     = wb_data_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance at ALU latency 1, one at latency 3,
// each driven by a strict ALU model whose result is only valid in the expected cycle.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        iv  [2];
    logic [15:0] ins [2];
    logic        ir  [2];
    logic        ae  [2];
    logic [3:0]  af  [2];
    logic [15:0] aa  [2];
    logic [15:0] bb  [2];
    logic [15:0] ao  [2];
    logic        wv  [2];
    logic [3:0]  wr  [2];
    logic [15:0] wd  [2];
    logic [3:0]  da  [2];
    logic [15:0] dd  [2];

    int n_checks = 0;
    int n_pass   = 0;

    alu_issue_ctrl #(.DATA_W(16), .NREGS(16), .ALU_LATENCY(1)) u_dut_lat1 (
        .clk(clk), .reset(reset), .instr_valid(iv[0]), .instr_ready(ir[0]), .instr(ins[0]),
        .alu_en(ae[0]), .alu_func(af[0]), .a(aa[0]), .b(bb[0]), .alu_out(ao[0]),
        .wb_valid(wv[0]), .wb_rd(wr[0]), .wb_data(wd[0]), .dbg_addr(da[0]), .dbg_data(dd[0])
    );

    alu_issue_ctrl #(.DATA_W(16), .NREGS(16), .ALU_LATENCY(3)) u_dut_lat3 (
        .clk(clk), .reset(reset), .instr_valid(iv[1]), .instr_ready(ir[1]), .instr(ins[1]),
        .alu_en(ae[1]), .alu_func(af[1]), .a(aa[1]), .b(bb[1]), .alu_out(ao[1]),
        .wb_valid(wv[1]), .wb_rd(wr[1]), .wb_data(wd[1]), .dbg_addr(da[1]), .dbg_data(dd[1])
    );

    // ALU model: result presented only in the cycle ALU_LATENCY after alu_en rises.
    for (genvar g = 0; g < 2; g++) begin : g_alu
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [7:0] en_cnt;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) en_cnt <= 8'd0;
            else if (ae[g]) en_cnt <= en_cnt + 8'd1;
            else en_cnt <= 8'd0;
        end
        assign ao[g] = (ae[g] && (en_cnt == 8'(LAT - 1)))
                       ? ((af[g] == 4'd0) ? aa[g] + bb[g] : aa[g] - bb[g])
                       : 16'hBAD0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Present one instruction at a negedge; it is consumed on the following posedge.
    task automatic present(input int d, input logic [15:0] val);
        iv[d]  = 1'b1;
        ins[d] = val;
        check("ready_on_present", 32'(ir[d]), 32'd1);
        @(negedge clk);
        iv[d] = 1'b0;
    endtask

    task automatic expect_wb(input int d, input logic [3:0] erd, input logic [15:0] edata);
        check("wb_valid", 32'(wv[d]), 32'd1);
        check("wb_rd", 32'(wr[d]), 32'(erd));
        check("wb_data", 32'(wd[d]), 32'(edata));
    endtask

    // Called at the negedge right after an ALU op was accepted.
    task automatic wait_wb(input int d, input int lat, input logic [3:0] f,
                           input logic [15:0] ea, input logic [15:0] eb,
                           input logic [3:0] erd, input logic [15:0] edata);
        int edges;
        int en_cyc;
        edges  = 1;
        en_cyc = 0;
        while (!wv[d] && edges < 20) begin
            if (ae[d]) en_cyc++;
            if (edges == 1) begin
                check("alu_func", 32'(af[d]), 32'(f));
                check("a", 32'(aa[d]), 32'(ea));
                check("b", 32'(bb[d]), 32'(eb));
                check("ready_in_exec", 32'(ir[d]), 32'd0);
            end
            @(negedge clk);
            edges++;
        end
        check("accept_to_wb", 32'(edges), 32'(lat + 1));
        check("alu_en_cycles", 32'(en_cyc), 32'(lat));
        expect_wb(d, erd, edata);
        check("alu_en_after", 32'(ae[d]), 32'd0);
        check("ready_after", 32'(ir[d]), 32'd1);
    endtask

    task automatic check_all_regs_zero(input int d);
        for (int r = 0; r < 16; r++) begin
            da[d] = 4'(r);
            #1;
            check("dbg_zero", 32'(dd[d]), 32'd0);
        end
    endtask

    task automatic run_scenarios(input int d, input int lat);
        present(d, 16'hF10A);
        expect_wb(d, 4'd1, 16'd10);
        da[d] = 4'd1;
        #1;
        check("dbg_r1", 32'(dd[d]), 32'd10);
        present(d, 16'hF205);
        expect_wb(d, 4'd2, 16'd5);
        present(d, 16'h0312);
        wait_wb(d, lat, 4'd0, 16'd10, 16'd5, 4'd3, 16'd15);
        present(d, 16'h0433);
        wait_wb(d, lat, 4'd0, 16'd15, 16'd15, 4'd4, 16'd30);
        present(d, 16'h1541);
        wait_wb(d, lat, 4'd1, 16'd30, 16'd10, 4'd5, 16'd20);
        present(d, 16'hF055);
        expect_wb(d, 4'd0, 16'h0055);
        da[d] = 4'd0;
        #1;
        check("dbg_r0", 32'(dd[d]), 32'd0);
        present(d, 16'h0301);
        wait_wb(d, lat, 4'd0, 16'd0, 16'd10, 4'd3, 16'd10);
        @(negedge clk);
        check("wb_valid_pulse", 32'(wv[d]), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d]  = 1'b0;
            ins[d] = 16'h0000;
            da[d]  = 4'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_alu_en", 32'(ae[d]), 32'd0);
            check("rst_alu_func", 32'(af[d]), 32'd0);
            check("rst_a", 32'(aa[d]), 32'd0);
            check("rst_b", 32'(bb[d]), 32'd0);
            check("rst_wb_valid", 32'(wv[d]), 32'd0);
            check("rst_wb_rd", 32'(wr[d]), 32'd0);
            check("rst_wb_data", 32'(wd[d]), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(ir[d]), 32'd1);
            check_all_regs_zero(d);
        end

        run_scenarios(0, 1);
        run_scenarios(1, 3);

        // Reset in the middle of a latency-3 operation.
        present(1, 16'h0312);
        check("mid_alu_en", 32'(ae[1]), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_alu_en", 32'(ae[1]), 32'd0);
        check("rst_mid_wb_valid", 32'(wv[1]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_wb_after_rst", 32'(wv[1]), 32'd0);
        end
        check("ready_after_rst", 32'(ir[1]), 32'd1);
        check_all_regs_zero(1);
        check_all_regs_zero(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
